// File: rtl/tdm_slot_rx_pkg.sv
// Types and constants shared by the TDM slot receiver, its queues and its interface.
`include "tdm_defs.v"

package tdm_slot_rx_pkg;
  localparam int WORD_W    = `TDM_WORD_W;
  localparam int NUM_SLOTS = `TDM_NUM_SLOTS;
  localparam int CNT_W     = `TDM_CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_e;

  function automatic fill_e fill_level(input int unsigned count, input int unsigned depth);
    if (count == 0) return FILL_EMPTY;
    if (count >= depth) return FILL_FULL;
    return FILL_PARTIAL;
  endfunction
endpackage

// File: rtl/tdm_slot_rx_if.sv
// Bus-side and consumer-side signals of tdm_slot_rx; drop counters exist only
// when TDM_SLOT_RX_STATS_EN is defined.
interface tdm_slot_rx_if import tdm_slot_rx_pkg::*; #(parameter int WIDTH = WORD_W);
  logic             in_valid;
  logic             in_slot;
  logic [WIDTH-1:0] in_data;
  logic             out_valid0;
  logic             out_valid1;
  logic             out_ready0;
  logic             out_ready1;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic             ovf0;
  logic             ovf1;
  logic             ovf_clr;
`ifdef TDM_SLOT_RX_STATS_EN
  logic [CNT_W-1:0] drop_cnt0;
  logic [CNT_W-1:0] drop_cnt1;

  modport slave (
    input  in_valid, in_slot, in_data, out_ready0, out_ready1, ovf_clr,
    output out_valid0, out_valid1, out_data0, out_data1, ovf0, ovf1,
           drop_cnt0, drop_cnt1
  );

  modport master (
    output in_valid, in_slot, in_data, out_ready0, out_ready1, ovf_clr,
    input  out_valid0, out_valid1, out_data0, out_data1, ovf0, ovf1,
           drop_cnt0, drop_cnt1
  );
`else
  modport slave (
    input  in_valid, in_slot, in_data, out_ready0, out_ready1, ovf_clr,
    output out_valid0, out_valid1, out_data0, out_data1, ovf0, ovf1
  );

  modport master (
    output in_valid, in_slot, in_data, out_ready0, out_ready1, ovf_clr,
    input  out_valid0, out_valid1, out_data0, out_data1, ovf0, ovf1
  );
`endif
endinterface

// File: rtl/tdm_defs.v
// Shared constants for the two-slot TDM result bus.
`ifndef TDM_DEFS_V
`define TDM_DEFS_V
`define TDM_WORD_W    16
`define TDM_NUM_SLOTS 2
`define TDM_SLOT0     1'b0
`define TDM_SLOT1     1'b1
`define TDM_CNT_W     8
`endif

// File: rtl/tdm_rx_fifo.sv
// Per-slot queue: registered head and valid, drop pulse when a push hits a full queue
// that is not popped on the same edge.
module tdm_rx_fifo
  import tdm_slot_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop_req,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             drop
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  fill_e            fill;
  logic             full;
  logic             pop;
  logic             accept;

  // A full queue still accepts when its head leaves on the same edge.
  always_comb begin
    fill   = fill_level(32'(count_q), 32'(DEPTH));
    valid  = (fill != FILL_EMPTY);
    full   = (fill == FILL_FULL);
    pop    = valid && pop_req;
    accept = push && (!full || pop);
    drop   = push && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !accept) count_q <= count_q - 1'b1;
    end
  end

  assign data_out = mem_q[rd_ptr_q];
endmodule

// File: rtl/tdm_slot_rx.sv
// Demultiplexes the two-slot TDM result bus into independent per-slot queues with
// sticky overflow flags; TDM_SLOT_RX_STATS_EN adds saturating per-slot drop counters.
`include "tdm_defs.v"

module tdm_slot_rx
  import tdm_slot_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_slot_rx_if.slave  bus
);
  logic                 push0;
  logic                 push1;
  logic                 drop0;
  logic                 drop1;
  logic [NUM_SLOTS-1:0] drop_vec;
  logic [NUM_SLOTS-1:0] ovf_q;

  assign push0 = bus.in_valid && (bus.in_slot == `TDM_SLOT0);
  assign push1 = bus.in_valid && (bus.in_slot == `TDM_SLOT1);

  tdm_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push0),
    .pop_req  (bus.out_ready0),
    .data_in  (bus.in_data),
    .data_out (bus.out_data0),
    .valid    (bus.out_valid0),
    .drop     (drop0)
  );

  tdm_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push1),
    .pop_req  (bus.out_ready1),
    .data_in  (bus.in_data),
    .data_out (bus.out_data1),
    .valid    (bus.out_valid1),
    .drop     (drop1)
  );

  assign drop_vec = {drop1, drop0};

  // A drop on the clearing edge wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= drop_vec | (bus.ovf_clr ? '0 : ovf_q);
  end

  assign bus.ovf0 = ovf_q[0];
  assign bus.ovf1 = ovf_q[1];

`ifdef TDM_SLOT_RX_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q [NUM_SLOTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) drop_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (bus.ovf_clr)
          drop_cnt_q[k] <= drop_vec[k] ? CNT_W'(1) : '0;
        else if (drop_vec[k] && (drop_cnt_q[k] != CNT_MAX))
          drop_cnt_q[k] <= drop_cnt_q[k] + 1'b1;
      end
    end
  end

  assign bus.drop_cnt0 = drop_cnt_q[0];
  assign bus.drop_cnt1 = drop_cnt_q[1];
`endif
endmodule
